// File: rtl/usb_tx_controller_if.sv
// Signal bundle for usb_tx_controller: the byte push handshake plus the FT245 write-side pins.
interface usb_tx_controller_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       txe_n_raw;
  logic       bus_busy;
  logic [7:0] data_bus_out;
  logic       data_out_enable;
  logic       wr_n;
  logic       tx_active;

  modport master (
    output in_data, in_valid, txe_n_raw, bus_busy,
    input  in_ready, data_bus_out, data_out_enable, wr_n, tx_active
  );

  modport slave (
    input  in_data, in_valid, txe_n_raw, bus_busy,
    output in_ready, data_bus_out, data_out_enable, wr_n, tx_active
  );
endinterface

// File: rtl/usb_tx_controller.sv
// FT245 transmit path: byte FIFO feeding a paced WR# strobe sequencer that shares the bus with the receive side.
// Optional send-immediate pulse after the FIFO drains is enabled by defining USB_TX_SEND_IMMEDIATE_EN.
module usb_tx_controller #(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = 4,
  parameter int WR_CYCLES      = 3,
  parameter int RECOVER_CYCLES = 4
`ifdef USB_TX_SEND_IMMEDIATE_EN
  , parameter int SI_CYCLES    = 13
`endif
) (
  input  logic                clk,
  input  logic                reset,
  usb_tx_controller_if.slave  bus,
  output logic [ADDR_W:0]     fifo_count,
  output logic [2:0]          state_out
`ifdef USB_TX_SEND_IMMEDIATE_EN
  , output logic              si_wu_n
`endif
);

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    RECOVER = 3'd4
`ifdef USB_TX_SEND_IMMEDIATE_EN
    , SI    = 3'd5
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sync1_q, txe_n_s_q;
  logic                rdy_q;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [7:0]          mem_q [DEPTH];
  logic [7:0]          dout_q, dout_d;
  logic                wr_n_q, wr_n_d;
  logic                oe_q, oe_d;
  logic                active_q, active_d;
  logic                push, pop;
`ifdef USB_TX_SEND_IMMEDIATE_EN
  logic                si_q, si_d;
`endif

  assign bus.in_ready        = rdy_q && (count_q != (ADDR_W+1)'(DEPTH));
  assign bus.data_bus_out    = dout_q;
  assign bus.data_out_enable = oe_q;
  assign bus.wr_n            = wr_n_q;
  assign bus.tx_active       = active_q;
  assign fifo_count          = count_q;
  assign state_out           = state_q;
`ifdef USB_TX_SEND_IMMEDIATE_EN
  assign si_wu_n             = si_q;
`endif

  assign push = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        // bus_busy only matters here; once SETUP is entered the cycle always completes
        if ((count_q != '0) && !txe_n_s_q && !bus.bus_busy) begin
          state_d = SETUP;
          pop     = 1'b1;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = '0;
      end
      STROBE: begin
        if (cnt_q == CNT_W'(WR_CYCLES - 1)) state_d = HOLD;
        else                                cnt_d   = cnt_q + CNT_W'(1);
      end
      HOLD: begin
        state_d = RECOVER;
        cnt_d   = '0;
      end
      RECOVER: begin
        if (cnt_q == CNT_W'(RECOVER_CYCLES - 1)) begin
          cnt_d = '0;
`ifdef USB_TX_SEND_IMMEDIATE_EN
          state_d = (count_q == '0) ? SI : IDLE;
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef USB_TX_SEND_IMMEDIATE_EN
      SI: begin
        if (cnt_q == CNT_W'(SI_CYCLES - 1)) state_d = IDLE;
        else                                cnt_d   = cnt_q + CNT_W'(1);
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    // Pin outputs are registered from the next state so they change cleanly on the edge
    dout_d   = pop ? mem_q[rd_ptr_q] : dout_q;
    wr_n_d   = (state_d != STROBE);
    oe_d     = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    active_d = oe_d;
`ifdef USB_TX_SEND_IMMEDIATE_EN
    si_d     = (state_d != SI);
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sync1_q   <= 1'b1;
      txe_n_s_q <= 1'b1;
      rdy_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dout_q    <= '0;
      wr_n_q    <= 1'b1;
      oe_q      <= 1'b0;
      active_q  <= 1'b0;
`ifdef USB_TX_SEND_IMMEDIATE_EN
      si_q      <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync1_q   <= bus.txe_n_raw;
      txe_n_s_q <= sync1_q;
      rdy_q     <= 1'b1;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dout_q    <= dout_d;
      wr_n_q    <= wr_n_d;
      oe_q      <= oe_d;
      active_q  <= active_d;
`ifdef USB_TX_SEND_IMMEDIATE_EN
      si_q      <= si_d;
`endif
    end
  end

endmodule

// File: tb/tb_usb_tx_controller.sv
// Randomised scoreboard bench for usb_tx_controller: accepted bytes are queued, a monitor checks each WR# strobe.
`timescale 1ns/1ps
module tb_usb_tx_controller;

  localparam int DEPTH          = 16;
  localparam int WR_CYCLES      = 3;
  localparam int RECOVER_CYCLES = 4;
  localparam int BYTE_CLKS      = 1 + WR_CYCLES + 1 + RECOVER_CYCLES + 1;
`ifdef USB_TX_SEND_IMMEDIATE_EN
  localparam int SI_CYCLES      = 13;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] fifo_count;
  logic [2:0] state_out;
`ifdef USB_TX_SEND_IMMEDIATE_EN
  logic       si_wu_n;
  int         si_pulses = 0;
  logic       prev_si   = 1'b1;
  int         si_low    = 0;
`endif

  int         total  = 0;
  int         bad    = 0;
  int         cyc    = 0;
  int         writes = 0;
  logic [7:0] exp_q[$];
  int         fall_q[$];
  logic       prev_wr = 1'b1;
  int         low_cnt = 0;

  usb_tx_controller_if bus();

  usb_tx_controller #(
    .DEPTH(DEPTH), .ADDR_W(4), .WR_CYCLES(WR_CYCLES), .RECOVER_CYCLES(RECOVER_CYCLES)
`ifdef USB_TX_SEND_IMMEDIATE_EN
    , .SI_CYCLES(SI_CYCLES)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .fifo_count(fifo_count),
    .state_out(state_out)
`ifdef USB_TX_SEND_IMMEDIATE_EN
    , .si_wu_n(si_wu_n)
`endif
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One push attempt; a byte joins the expected stream only if the handshake completes.
  task automatic applyStimulus(input logic [7:0] b, input bit v, output bit accepted);
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = v;
    accepted     = v && (bus.in_ready === 1'b1);
    if (accepted) exp_q.push_back(b);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && state_out == 3'd0 && fifo_count == 5'd0) && n < 3000);
    checkOutput({name, "_drained"}, (n < 3000), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic waitWr(input logic level, input string name);
    int n = 0;
    while (bus.wr_n !== level && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, bus.wr_n, level);
  endtask

  // Monitor: every completed WR# strobe must carry the oldest outstanding byte with the right width.
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      prev_wr = 1'b1;
      low_cnt = 0;
`ifdef USB_TX_SEND_IMMEDIATE_EN
      prev_si = 1'b1;
      si_low  = 0;
`endif
    end else begin
      if (bus.wr_n === 1'b0) begin
        if (prev_wr === 1'b1) fall_q.push_back(cyc);
        low_cnt++;
        checkOutput("oe_during_strobe", bus.data_out_enable, 1);
      end else if (prev_wr === 1'b0) begin
        checkOutput("strobe_len", low_cnt, WR_CYCLES);
        checkOutput("oe_in_hold", bus.data_out_enable, 1);
        checkOutput("active_in_hold", bus.tx_active, 1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_write: got %0h expected no write", bus.data_bus_out);
        end else begin
          checkOutput("write_data", bus.data_bus_out, exp_q.pop_front());
        end
        writes++;
        low_cnt = 0;
      end
      prev_wr = bus.wr_n;
`ifdef USB_TX_SEND_IMMEDIATE_EN
      if (si_wu_n === 1'b0) begin
        si_low++;
      end else if (prev_si === 1'b0) begin
        checkOutput("si_len", si_low, SI_CYCLES);
        si_pulses++;
        si_low = 0;
      end
      prev_si = si_wu_n;
`endif
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    int n;
    int w0;
    int nacc;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.txe_n_raw = 1'b1;
    bus.bus_busy  = 1'b0;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_wr_n", bus.wr_n, 1);
    checkOutput("rst_oe", bus.data_out_enable, 0);
    checkOutput("rst_data", bus.data_bus_out, 0);
    checkOutput("rst_active", bus.tx_active, 0);
    checkOutput("rst_count", fifo_count, 0);
    checkOutput("rst_state", state_out, 0);
`ifdef USB_TX_SEND_IMMEDIATE_EN
    checkOutput("rst_si", si_wu_n, 1);
`endif
    reset = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_after_reset", bus.in_ready, 1);

    // Single byte held back by TXE#, then released
    applyStimulus(8'hA5, 1'b1, acc);
    checkOutput("a5_accept", acc, 1);
    repeat (5) @(negedge clk);
    checkOutput("a5_count", fifo_count, 1);
    checkOutput("a5_wr_idle", bus.wr_n, 1);
    @(negedge clk);
    #1 bus.txe_n_raw = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.data_out_enable !== 1'b1 && n < 20);
    checkOutput("oe_latency", n, 3);
    checkOutput("setup_data", bus.data_bus_out, 8'hA5);
    checkOutput("setup_wr_n", bus.wr_n, 1);
    drain("a5");

    // Three back-to-back bytes: one strobe every BYTE_CLKS clocks
    fall_q.delete();
    applyStimulus(8'h01, 1'b1, acc);
    applyStimulus(8'h02, 1'b1, acc);
    applyStimulus(8'h03, 1'b1, acc);
    drain("b2b");
    checkOutput("b2b_pulses", fall_q.size(), 3);
    if (fall_q.size() == 3) begin
      checkOutput("b2b_gap1", fall_q[1] - fall_q[0], BYTE_CLKS);
      checkOutput("b2b_gap2", fall_q[2] - fall_q[1], BYTE_CLKS);
    end
    checkOutput("b2b_count", fifo_count, 0);

    // Fill past capacity with TXE# high
    #1 bus.txe_n_raw = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(8'h10 + 8'(i), 1'b1, acc);
      checkOutput("full_accept", acc, (i < DEPTH));
    end
    @(negedge clk);
    checkOutput("full_count", fifo_count, DEPTH);
    checkOutput("full_in_ready", bus.in_ready, 0);
    checkOutput("full_no_write", bus.wr_n, 1);
    w0 = writes;
    #1 bus.txe_n_raw = 1'b0;
    drain("full");
    checkOutput("full_writes", writes - w0, DEPTH);

    // bus_busy holds off SETUP but cannot abort a started cycle
    #1 bus.bus_busy = 1'b1;
    applyStimulus(8'h5A, 1'b1, acc);
    repeat (20) @(negedge clk);
    checkOutput("busy_no_setup", bus.data_out_enable, 0);
    checkOutput("busy_count", fifo_count, 1);
    #1 bus.bus_busy = 1'b0;
    @(negedge clk);
    checkOutput("busy_drop_setup", bus.data_out_enable, 1);
    w0 = writes;
    waitWr(1'b0, "busy_strobe_seen");
    #1 bus.bus_busy = 1'b1;
    n = 0;
    while (writes == w0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_cycle_completes", writes - w0, 1);
    #1 bus.bus_busy = 1'b0;
    drain("busy");

    // Reset in the middle of a strobe discards everything
    applyStimulus(8'hC1, 1'b1, acc);
    applyStimulus(8'hC2, 1'b1, acc);
    applyStimulus(8'hC3, 1'b1, acc);
    waitWr(1'b0, "rst_mid_strobe_seen");
    @(negedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    checkOutput("mid_rst_wr_n", bus.wr_n, 1);
    checkOutput("mid_rst_oe", bus.data_out_enable, 0);
    checkOutput("mid_rst_count", fifo_count, 0);
    checkOutput("mid_rst_state", state_out, 0);
    checkOutput("mid_rst_in_ready", bus.in_ready, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("mid_rst_idle_wr_n", bus.wr_n, 1);

    // Randomised traffic with TXE# and bus_busy wandering
    w0   = writes;
    nacc = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) bus.txe_n_raw = ~bus.txe_n_raw;
      if ($urandom_range(0, 4) == 0) bus.bus_busy = ~bus.bus_busy;
      applyStimulus(8'($urandom), ($urandom_range(0, 1) == 1), acc);
      if (acc) nacc++;
    end
    bus.txe_n_raw = 1'b0;
    bus.bus_busy  = 1'b0;
    drain("random");
    checkOutput("random_writes", writes - w0, nacc);
    checkOutput("random_count", fifo_count, 0);

`ifdef USB_TX_SEND_IMMEDIATE_EN
    si_pulses = 0;
    applyStimulus(8'hE1, 1'b1, acc);
    drain("si_one");
    checkOutput("si_one_pulses", si_pulses, 1);
    si_pulses = 0;
    applyStimulus(8'hE2, 1'b1, acc);
    applyStimulus(8'hE3, 1'b1, acc);
    drain("si_two");
    checkOutput("si_two_pulses", si_pulses, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
